// File: rtl/cpmath_pkg.sv
// Shared load-size encodings, buffer defaults and entry layout for the writeback path.
package cpmath_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } ld_size_e;

  localparam int LD_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Lane select, sign/zero extension and legality check for a raw little-endian load word.
module load_align
  import cpmath_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic [31:0] ld_data,
  output logic        ld_reject
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    ld_data   = 32'h0000_0000;
    ld_reject = 1'b0;

    case (ld_addr_lo)
      2'd0:    byte_lane = ld_word[7:0];
      2'd1:    byte_lane = ld_word[15:8];
      2'd2:    byte_lane = ld_word[23:16];
      default: byte_lane = ld_word[31:24];
    endcase
    half_lane = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

    case (ld_size_e'(ld_size))
      LS_BYTE: ld_data = {{24{ld_signed & byte_lane[7]}}, byte_lane};
      LS_HALF: begin
        ld_data   = {{16{ld_signed & half_lane[15]}}, half_lane};
        ld_reject = ld_addr_lo[0];
      end
      LS_WORD: begin
        ld_data   = ld_word;
        ld_reject = (ld_addr_lo != 2'b00);
      end
      default: ld_reject = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results win, aligned loads wait in a small FIFO
// that is forced to drain once full.
module writeback_unit
  import cpmath_pkg::*;
#(
  parameter int LD_DEPTH = LD_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_dest,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] ld_pending,
  output logic        load_err
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          load_err_q, load_err_d;
  wb_entry_t     fifo_q [LD_DEPTH];

  logic [31:0]   ld_aligned;
  logic          ld_reject;
  logic          has_room;
  logic          alu_fire, ld_fire, push, pop;
  wb_entry_t     sel;
  logic [31:0]   pend;
  logic [PW-1:0] slot;

  load_align u_align (
    .ld_word    (ld_word),
    .ld_addr_lo (ld_addr_lo),
    .ld_size    (ld_size),
    .ld_signed  (ld_signed),
    .ld_data    (ld_aligned),
    .ld_reject  (ld_reject)
  );

  always_comb begin
    has_room  = (count_q < DEPTH_C);
    alu_ready = has_room;
    ld_ready  = has_room;
    alu_fire  = alu_valid & has_room;
    ld_fire   = ld_valid & has_room;
    push      = ld_fire & ~ld_reject;
    // A full buffer blocks the ALU, so the head always gets a slot here.
    pop       = ~alu_fire & (count_q != '0);
    sel       = alu_fire ? wb_entry_t'({alu_dest, alu_data}) : fifo_q[rd_ptr_q];

    reg_write_d  = (alu_fire | pop) & (sel.dest != 5'd0);
    write_reg_d  = reg_write_d ? sel.dest : write_reg_q;
    write_data_d = reg_write_d ? sel.data : write_data_q;
    load_err_d   = ld_fire & ld_reject;

    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_comb begin
    pend = 32'h0000_0000;
    slot = '0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      slot = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) pend[fifo_q[slot].dest] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'h0000_0000;
      load_err_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      load_err_q   <= load_err_d;
    end
  end

  // Storage needs no reset: entries are only visible below count_q.
  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr_q] <= {ld_dest, ld_aligned};
  end

  assign regWrite   = reg_write_q;
  assign writeReg   = write_reg_q;
  assign writeData  = write_data_q;
  assign load_err   = load_err_q;
  assign ld_pending = pend;

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter LD_DEPTH, default 4, meaning load-result buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports alu_valid  input  1, alu_ready  output  1, alu_dest  input  5, alu_data  input  32: ALU result handshake.
REQ-005 SHALL have ports ld_valid  input  1, ld_ready  output  1, ld_dest  input  5, ld_word  input  32 (raw memory word), ld_addr_lo  input  2, ld_size  input  2, ld_signed  input  1: load result handshake.
REQ-006 SHALL have ports regWrite  output  1, writeReg  output  5, writeData  output  32: register-file write port, all registered.
REQ-007 SHALL have port ld_pending  output  32: bit n set while any buffered load entry targets register n.
REQ-008 SHALL have port load_err  output  1: registered one-cycle pulse for a rejected load.

Function
REQ-009 SHALL accept a transfer on a channel when valid and ready are both high at posedge clk.
REQ-010 SHALL drive ld_ready = (count < LD_DEPTH) and alu_ready = (count < LD_DEPTH), both from registered count only.
REQ-011 SHALL, on load accept, align and extend: size 00 byte lane ld_addr_lo, size 01 halfword lane ld_addr_lo[1], size 10 full word; ld_signed=1 sign-extends, 0 zero-extends; little-endian lanes.
REQ-012 SHALL reject (not buffer) a load with size 11, size 01 with ld_addr_lo[0]=1, or size 10 with ld_addr_lo!=0, pulsing load_err the following cycle.
REQ-013 SHALL buffer accepted, non-rejected loads in a FIFO of aligned data plus dest.
REQ-014 SHALL per cycle select at most one write: accepted ALU result if any, else FIFO head if count>0, else none.
REQ-015 SHALL, when count==LD_DEPTH, hold alu_ready low and pop the FIFO head, guaranteeing load forward progress.
REQ-016 SHALL register the selected write so regWrite/writeReg/writeData appear exactly 1 cycle after acceptance (ALU) or pop (load).
REQ-017 SHALL drive regWrite=0 when nothing is selected or the selected dest is 0; selected dest-0 entries are still consumed/popped.
REQ-018 SHALL hold writeReg/writeData at their last values when regWrite=0.
REQ-019 SHALL support simultaneous push and pop in one cycle; count unchanged, no data loss.
REQ-020 SHALL wrap read/write pointers modulo LD_DEPTH.
REQ-021 SHALL compute ld_pending combinationally from valid FIFO entries only; bit 0 always 0.

Reset
REQ-022 SHALL, with reset high at posedge clk, clear count, pointers, regWrite, writeReg, writeData, load_err; ld_pending reads 0 next cycle.
REQ-023 SHALL discard buffered entries and any same-cycle handshake when reset asserts mid-operation; no write issues in the cycle after reset.
REQ-024 SHALL give reset priority over all other updates.

Structure
REQ-025 SHALL place ld_size encodings (LS_BYTE=00, LS_HALF=01, LS_WORD=10) and default LD_DEPTH in shared package cpmath_pkg.
REQ-026 SHALL implement align/extend/reject as combinational sub-module load_align; FIFO and arbitration stay in writeback_unit.

Verification
REQ-027 SHALL test: ALU valid dest=5 data=0x12345678 -> next cycle regWrite=1, writeReg=5, writeData=0x12345678.
REQ-028 SHALL test: load word 0x80FF7F01, size 00, addr_lo 1, signed=1 -> written data 0x0000007F; addr_lo 3 signed=1 -> 0xFFFFFF80; size 01, addr_lo 2, signed=0 -> 0x000080FF.
REQ-029 SHALL test: load size 01 addr_lo 1 -> load_err pulses 1 cycle, no write, count unchanged.
REQ-030 SHALL test: ALU valid every cycle plus 5 loads -> FIFO fills to 4, ld_ready and alu_ready drop, head pops, all 5 loads written in order, ld_pending tracks dests.
REQ-031 SHALL test: ALU dest=0 data=0xDEADBEEF -> regWrite stays 0; writeReg/writeData unchanged.
REQ-032 SHALL test: 3 loads buffered, reset for 1 cycle -> count=0, ld_pending=0, regWrite=0, no buffered load ever written.
